m68k_bus_responder: RTL and testbench

Synthesizable 68000 bus slave that answers the asynchronous read/write cycles of a 68000-family initiator on behalf of one decoded address window. It synchronizes AS/UDS/LDS into the local clock domain, hands each selected cycle to a simple internal req/ack backend, and terminates the bus cycle with DTACK, or with BERR on backend timeout. It is the responder at the opposite end of the bus from the CPU (or from the simulated initiator used in testbenches).

---
 rtl/m68k_bus_pkg.sv | 29 ++
 rtl/m68k_sync.sv | 28 ++
 rtl/m68k_bus_responder.sv | 151 +++++++++++++++
 tb/tb_m68k_bus_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000 bus responder.
package m68k_bus_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;

  // Function code for CPU space (interrupt acknowledge etc.), never decoded as memory.
  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ACCESS,
    ST_ACK,
    ST_ERR,
    ST_IGNORE
  } state_e;

  // Window decode: masked address match, excluding CPU space cycles.
  function automatic logic addr_hit(
    input logic [ADDR_W-1:0] a,
    input logic [2:0]        fc,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] mask
  );
    return ((a & mask) == (base & mask)) && (fc != FC_CPU_SPACE);
  endfunction

endpackage

// File: rtl/m68k_sync.sv
// Two-flop synchronizer for asynchronous, active-low bus strobes.
module m68k_sync #(
  parameter int unsigned WIDTH     = 1,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Resolve metastability over two stages; reset to the deasserted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {WIDTH{RESET_VAL}};
      sync_q <= {WIDTH{RESET_VAL}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 bus slave: answers one decoded address window through a req/ack backend,
// terminating each cycle with DTACK, or BERR when the backend times out.
module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 24'hE00000,
  parameter logic [ADDR_W-1:0] ADDR_MASK      = 24'hF00000,
  parameter int unsigned       TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  inout  logic [DATA_W-1:0] data,
  input  logic              as_n,
  input  logic              uds_n,
  input  logic              lds_n,
  input  logic              read,
  input  logic [2:0]        fc,
  output logic              dtack_n,
  output logic              berr_n,
  output logic              be_req,
  output logic              be_we,
  output logic [ADDR_W-2:0] be_addr,
  output logic [1:0]        be_be,
  output logic [DATA_W-1:0] be_wdata,
  input  logic [DATA_W-1:0] be_rdata,
  input  logic              be_ack
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [2:0] strb_s_n;
  logic       as_s;
  logic       ds_s;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                be_req_q;
  logic                be_we_q;
  logic [ADDR_W-2:0]   be_addr_q;
  logic [1:0]          be_be_q;
  logic [DATA_W-1:0]   be_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                dtack_q;
  logic                berr_q;
  logic                drive_q;

  m68k_sync #(
    .WIDTH     (3),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({as_n, uds_n, lds_n}),
    .q_o   (strb_s_n)
  );

  assign as_s = ~strb_s_n[2];
  assign ds_s = ~strb_s_n[1] | ~strb_s_n[0];

  // Bus-cycle FSM with registered backend request and bus-termination outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      be_req_q   <= 1'b0;
      be_we_q    <= 1'b0;
      be_addr_q  <= '0;
      be_be_q    <= '0;
      be_wdata_q <= '0;
      rdata_q    <= '0;
      dtack_q    <= 1'b0;
      berr_q     <= 1'b0;
      drive_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (as_s) state_q <= ST_SELECT;
        end
        ST_SELECT: begin
          if (!as_s) begin
            state_q <= ST_IDLE;
          end else if (ds_s) begin
            if (addr_hit(addr, fc, BASE_ADDR, ADDR_MASK)) begin
              be_addr_q  <= addr[ADDR_W-1:1];
              be_we_q    <= ~read;
              be_be_q    <= {~uds_n, ~lds_n};
              be_wdata_q <= data;
              be_req_q   <= 1'b1;
              cnt_q      <= '0;
              state_q    <= ST_ACCESS;
            end else begin
              state_q <= ST_IGNORE;
            end
          end
        end
        ST_ACCESS: begin
          // be_req low while still in ACCESS marks a timed-out request: one drain
          // cycle so BERR never overlaps be_req.
          if (!be_req_q) begin
            berr_q  <= as_s;
            state_q <= as_s ? ST_ERR : ST_IDLE;
          end else if (be_ack) begin
            be_req_q <= 1'b0;
            rdata_q  <= be_rdata;
            if (as_s) begin
              dtack_q <= 1'b1;
              drive_q <= ~be_we_q;
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (TO_EN && (cnt_q == CNT_LAST)) be_req_q <= 1'b0;
          end
        end
        ST_ACK: begin
          if (!as_s) begin
            dtack_q <= 1'b0;
            drive_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (!as_s) begin
            berr_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_IGNORE: begin
          if (!as_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign be_req   = be_req_q;
  assign be_we    = be_we_q;
  assign be_addr  = be_addr_q;
  assign be_be    = be_be_q;
  assign be_wdata = be_wdata_q;

  assign dtack_n = dtack_q ? 1'b0 : 1'bz;
  assign berr_n  = berr_q  ? 1'b0 : 1'bz;
  assign data    = drive_q ? rdata_q : 'z;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Self-checking bench for m68k_bus_responder: directed scenarios plus randomized cycles.
`timescale 1ns/1ps
module tb_m68k_bus_responder;

  localparam logic [23:0] BASE = 24'hE00000;
  localparam logic [23:0] MASK = 24'hF00000;
  localparam int          TO   = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] addr;
  logic        as_n, uds_n, lds_n, read;
  logic [2:0]  fc;
  tri1  [15:0] data;
  tri1         dtack_n;
  tri1         berr_n;
  logic        tb_drv;
  logic [15:0] tb_wd;
  logic        be_req, be_we, be_ack;
  logic [22:0] be_addr;
  logic [1:0]  be_be;
  logic [15:0] be_wdata, be_rdata;

  int checks   = 0;
  int failures = 0;

  assign data = tb_drv ? tb_wd : 'z;

  always #5 clk = ~clk;

  m68k_bus_responder #(
    .BASE_ADDR      (BASE),
    .ADDR_MASK      (MASK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data     (data),
    .as_n     (as_n),
    .uds_n    (uds_n),
    .lds_n    (lds_n),
    .read     (read),
    .fc       (fc),
    .dtack_n  (dtack_n),
    .berr_n   (berr_n),
    .be_req   (be_req),
    .be_we    (be_we),
    .be_addr  (be_addr),
    .be_be    (be_be),
    .be_wdata (be_wdata),
    .be_rdata (be_rdata),
    .be_ack   (be_ack)
  );

  typedef struct packed {
    bit req;
    int req_lat;
    int req_len;
    bit dtack;
    bit berr;
    int resp_lat;
  } exp_t;

  // Expected outcome of one bus cycle, from the decode and termination rules.
  function automatic exp_t model(input logic [23:0] a, input logic [2:0] f, input int ack_dly,
                                 input int ds_lag, input bit withdraw);
    exp_t m;
    bit hit, acked;
    hit   = ((a & MASK) == (BASE & MASK)) && (f != 3'b111);
    acked = (ack_dly >= 0) && (ack_dly < TO);
    m.req      = hit;
    m.req_lat  = (ds_lag == 0) ? 4 : 3;
    m.req_len  = acked ? ack_dly + 1 : TO;
    m.dtack    = hit && acked && !withdraw;
    m.berr     = hit && !acked && !withdraw;
    m.resp_lat = acked ? ack_dly + 1 : TO + 1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one 68k bus cycle, act as backend, and report what was observed.
  task automatic run_cycle(
    input  logic [23:0] a, input bit rd, input logic [2:0] f, input logic [1:0] lanes,
    input  logic [15:0] wd, input logic [15:0] rdv, input int ack_dly, input int ds_lag,
    input  bit withdraw,
    output int req_lat, output logic [22:0] o_addr, output logic [1:0] o_be, output bit o_we,
    output logic [15:0] o_wd, output int req_len, output int resp_lat, output bit o_dtack,
    output bit o_berr, output logic [1:0] o_hold, output logic [15:0] o_rd, output bit overlap,
    output bit rel_ok);
    int e, t;
    req_lat = -1; req_len = 0; resp_lat = -1; o_dtack = 0; o_berr = 0; overlap = 0;
    o_rd = '0; o_addr = '0; o_be = '0; o_we = 0; o_wd = '0; rel_ok = 0; o_hold = '0;
    addr = a; read = rd; fc = f; as_n = 1'b0;
    if (!rd) begin tb_drv = 1'b1; tb_wd = wd; end
    for (int i = 0; i < ds_lag; i++) tick();
    uds_n = ~lanes[1]; lds_n = ~lanes[0];
    e = 0;
    while (be_req !== 1'b1 && e < 8) begin tick(); e++; end
    t = 0;
    if (be_req === 1'b1) begin
      req_lat = e; o_addr = be_addr; o_be = be_be; o_we = be_we; o_wd = be_wdata;
      if (withdraw) begin as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; tb_drv = 1'b0; end
      while (be_req === 1'b1 && t < 100) begin
        req_len++;
        if (berr_n === 1'b0) overlap = 1;
        if (t == ack_dly) begin be_ack = 1'b1; be_rdata = rdv; end
        tick();
        be_ack = 1'b0;
        t++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (berr_n === 1'b0 && be_req === 1'b1) overlap = 1;
      if (dtack_n === 1'b0 && !o_dtack && !o_berr) begin o_dtack = 1; resp_lat = t; o_rd = data; end
      if (berr_n === 1'b0 && !o_berr && !o_dtack) begin o_berr = 1; resp_lat = t; end
      tick();
      t++;
    end
    if (!o_dtack) o_rd = data;
    o_hold = {dtack_n === 1'b0, berr_n === 1'b0};
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; tb_drv = 1'b0;
    tick(); tick(); tick();
    rel_ok = (dtack_n === 1'b1) && (berr_n === 1'b1) && (data === 16'hFFFF) && (be_req === 1'b0);
    tick();
  endtask

  int          r_lat, r_len, r_resp;
  logic [22:0] r_addr;
  logic [1:0]  r_be, r_hold;
  bit          r_we, r_dt, r_be_err, r_ovl, r_rel;
  logic [15:0] r_wd, r_rd;

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (be_req !== 1'b0 || be_we !== 1'b0) begin failures++; $display("FAIL reset_req: req=%b we=%b expected 0 0", be_req, be_we); end
    checks++; if ({be_addr, be_be, be_wdata} !== '0) begin failures++; $display("FAIL reset_capture: addr=%h be=%b wdata=%h expected zeros", be_addr, be_be, be_wdata); end
    checks++; if (dtack_n !== 1'b1 || berr_n !== 1'b1 || data !== 16'hFFFF) begin failures++; $display("FAIL reset_bus: dtack=%b berr=%b data=%h expected released", dtack_n, berr_n, data); end
    rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (be_req !== 1'b0 || dtack_n !== 1'b1) begin failures++; $display("FAIL reset_idle: req=%b dtack=%b expected 0 1", be_req, dtack_n); end
  endtask

  task automatic test_word_read();
    run_cycle(24'hE00010, 1, 3'b101, 2'b11, 16'h0, 16'hBEEF, 2, 0, 0,
              r_lat, r_addr, r_be, r_we, r_wd, r_len, r_resp, r_dt, r_be_err, r_hold, r_rd, r_ovl, r_rel);
    checks++; if (r_lat !== 4) begin failures++; $display("FAIL read_req_latency: got %0d expected 4", r_lat); end
    checks++; if (r_addr !== 23'h700008 || r_be !== 2'b11 || r_we !== 1'b0) begin failures++; $display("FAIL read_capture: addr=%h be=%b we=%b expected 700008 11 0", r_addr, r_be, r_we); end
    checks++; if (!r_dt || r_be_err || r_resp !== 3) begin failures++; $display("FAIL read_dtack: dtack=%b berr=%b lat=%0d expected 1 0 3", r_dt, r_be_err, r_resp); end
    checks++; if (r_rd !== 16'hBEEF) begin failures++; $display("FAIL read_data: got %h expected BEEF", r_rd); end
    checks++; if (!r_rel) begin failures++; $display("FAIL read_release: got %b expected 1", r_rel); end
  endtask

  task automatic test_byte_write();
    run_cycle(24'hE00021, 0, 3'b101, 2'b01, 16'h0055, 16'h0, 1, 1, 0,
              r_lat, r_addr, r_be, r_we, r_wd, r_len, r_resp, r_dt, r_be_err, r_hold, r_rd, r_ovl, r_rel);
    checks++; if (r_lat !== 3) begin failures++; $display("FAIL write_req_latency: got %0d expected 3", r_lat); end
    checks++; if (r_we !== 1'b1 || r_be !== 2'b01 || r_wd !== 16'h0055 || r_addr !== 23'h700010) begin failures++; $display("FAIL write_capture: we=%b be=%b wdata=%h addr=%h expected 1 01 0055 700010", r_we, r_be, r_wd, r_addr); end
    checks++; if (!r_dt || r_be_err) begin failures++; $display("FAIL write_dtack: dtack=%b berr=%b expected 1 0", r_dt, r_be_err); end
    checks++; if (!r_rel) begin failures++; $display("FAIL write_release: got %b expected 1", r_rel); end
  endtask

  task automatic test_miss();
    logic [23:0] al [2] = '{24'h100000, 24'hE00010};
    logic [2:0]  fl [2] = '{3'b101, 3'b111};
    for (int i = 0; i < 2; i++) begin
      run_cycle(al[i], 1, fl[i], 2'b11, 16'h0, 16'h1111, 0, 0, 0,
                r_lat, r_addr, r_be, r_we, r_wd, r_len, r_resp, r_dt, r_be_err, r_hold, r_rd, r_ovl, r_rel);
      checks++; if (r_lat !== -1 || r_dt || r_be_err) begin failures++; $display("FAIL miss_%0d: req_lat=%0d dtack=%b berr=%b expected -1 0 0", i, r_lat, r_dt, r_be_err); end
      checks++; if (r_rd !== 16'hFFFF || !r_rel) begin failures++; $display("FAIL miss_bus_%0d: data=%h rel=%b expected FFFF 1", i, r_rd, r_rel); end
    end
  endtask

  task automatic test_timeout();
    run_cycle(24'hE12346, 1, 3'b110, 2'b11, 16'h0, 16'h0, -1, 0, 0,
              r_lat, r_addr, r_be, r_we, r_wd, r_len, r_resp, r_dt, r_be_err, r_hold, r_rd, r_ovl, r_rel);
    checks++; if (r_len !== TO) begin failures++; $display("FAIL timeout_req_len: got %0d expected %0d", r_len, TO); end
    checks++; if (!r_be_err || r_dt || r_resp !== TO + 1) begin failures++; $display("FAIL timeout_berr: berr=%b dtack=%b lat=%0d expected 1 0 %0d", r_be_err, r_dt, r_resp, TO + 1); end
    checks++; if (r_hold !== 2'b01 || r_ovl) begin failures++; $display("FAIL timeout_hold: hold=%b overlap=%b expected 01 0", r_hold, r_ovl); end
    checks++; if (r_rd !== 16'hFFFF || !r_rel) begin failures++; $display("FAIL timeout_bus: data=%h rel=%b expected FFFF 1", r_rd, r_rel); end
  endtask

  task automatic test_ack_at_timeout();
    run_cycle(24'hE00100, 1, 3'b101, 2'b11, 16'h0, 16'hC0DE, TO - 1, 0, 0,
              r_lat, r_addr, r_be, r_we, r_wd, r_len, r_resp, r_dt, r_be_err, r_hold, r_rd, r_ovl, r_rel);
    checks++; if (!r_dt || r_be_err || r_resp !== TO) begin failures++; $display("FAIL ack_at_timeout: dtack=%b berr=%b lat=%0d expected 1 0 %0d", r_dt, r_be_err, r_resp, TO); end
    checks++; if (r_rd !== 16'hC0DE) begin failures++; $display("FAIL ack_at_timeout_data: got %h expected C0DE", r_rd); end
  endtask

  task automatic test_withdraw();
    run_cycle(24'hE00200, 1, 3'b101, 2'b11, 16'h0, 16'h7777, 2, 0, 1,
              r_lat, r_addr, r_be, r_we, r_wd, r_len, r_resp, r_dt, r_be_err, r_hold, r_rd, r_ovl, r_rel);
    checks++; if (r_lat !== 4 || r_len !== 3) begin failures++; $display("FAIL withdraw_req: lat=%0d len=%0d expected 4 3", r_lat, r_len); end
    checks++; if (r_dt || r_be_err || r_rd !== 16'hFFFF) begin failures++; $display("FAIL withdraw_term: dtack=%b berr=%b data=%h expected 0 0 FFFF", r_dt, r_be_err, r_rd); end
    run_cycle(24'hE00202, 1, 3'b101, 2'b11, 16'h0, 16'h8421, 0, 0, 0,
              r_lat, r_addr, r_be, r_we, r_wd, r_len, r_resp, r_dt, r_be_err, r_hold, r_rd, r_ovl, r_rel);
    checks++; if (!r_dt || r_rd !== 16'h8421 || r_addr !== 23'h700101) begin failures++; $display("FAIL withdraw_next: dtack=%b data=%h addr=%h expected 1 8421 700101", r_dt, r_rd, r_addr); end
  endtask

  task automatic test_reset_in_ack();
    int e;
    addr = 24'hE00040; read = 1'b1; fc = 3'b110; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    e = 0;
    while (be_req !== 1'b1 && e < 10) begin tick(); e++; end
    checks++; if (be_req !== 1'b1) begin failures++; $display("FAIL rst_ack_req: req=%b expected 1 within 10 edges", be_req); end
    be_ack = 1'b1; be_rdata = 16'h1234;
    tick();
    be_ack = 1'b0;
    checks++; if (dtack_n !== 1'b0 || data !== 16'h1234) begin failures++; $display("FAIL rst_ack_pre: dtack=%b data=%h expected 0 1234", dtack_n, data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dtack_n !== 1'b1 || data !== 16'hFFFF || be_req !== 1'b0 || be_addr !== 23'h0) begin failures++; $display("FAIL rst_ack_async: dtack=%b data=%h req=%b addr=%h expected 1 FFFF 0 0", dtack_n, data, be_req, be_addr); end
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (be_req !== 1'b0 || dtack_n !== 1'b1) begin failures++; $display("FAIL rst_ack_idle: req=%b dtack=%b expected 0 1", be_req, dtack_n); end
    run_cycle(24'hE00042, 1, 3'b101, 2'b10, 16'h0, 16'hA5C3, 1, 0, 0,
              r_lat, r_addr, r_be, r_we, r_wd, r_len, r_resp, r_dt, r_be_err, r_hold, r_rd, r_ovl, r_rel);
    checks++; if (r_lat !== 4 || !r_dt || r_rd !== 16'hA5C3 || r_addr !== 23'h700021 || r_be !== 2'b10) begin failures++; $display("FAIL rst_ack_next: lat=%0d dtack=%b data=%h addr=%h be=%b expected 4 1 A5C3 700021 10", r_lat, r_dt, r_rd, r_addr, r_be); end
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic [2:0]  f;
    logic [1:0]  lanes;
    logic [15:0] wd, rdv;
    bit          rd, wdr;
    int          ack_dly, ds_lag, nib, r;
    exp_t        m;
    for (int it = 0; it < 40; it++) begin
      nib = $urandom_range(0, 14);
      if ($urandom_range(0, 1) == 1) nib = 14;
      else if (nib == 14) nib = 15;
      a       = {nib[3:0], 20'($urandom)};
      f       = ($urandom_range(0, 4) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
      rd      = 1'($urandom);
      lanes   = 2'($urandom_range(1, 3));
      wd      = 16'($urandom);
      rdv     = 16'($urandom);
      r       = $urandom_range(0, 7);
      ack_dly = (r == 7) ? -1 : r;
      ds_lag  = $urandom_range(0, 2);
      wdr     = ($urandom_range(0, 5) == 0) && (ack_dly < 0 || ack_dly >= 2);
      m = model(a, f, ack_dly, ds_lag, wdr);
      run_cycle(a, rd, f, lanes, wd, rdv, ack_dly, ds_lag, wdr,
                r_lat, r_addr, r_be, r_we, r_wd, r_len, r_resp, r_dt, r_be_err, r_hold, r_rd, r_ovl, r_rel);
      if (m.req) begin
        checks++; if (r_lat !== m.req_lat) begin failures++; $display("FAIL rnd%0d_req_lat: got %0d expected %0d", it, r_lat, m.req_lat); end
        checks++; if ({r_addr, r_be, r_we} !== {a[23:1], lanes, ~rd}) begin failures++; $display("FAIL rnd%0d_capture: addr=%h be=%b we=%b expected %h %b %b", it, r_addr, r_be, r_we, a[23:1], lanes, ~rd); end
        if (!rd) begin checks++; if (r_wd !== wd) begin failures++; $display("FAIL rnd%0d_wdata: got %h expected %h", it, r_wd, wd); end end
        checks++; if (r_len !== m.req_len) begin failures++; $display("FAIL rnd%0d_req_len: got %0d expected %0d", it, r_len, m.req_len); end
      end else begin
        checks++; if (r_lat !== -1) begin failures++; $display("FAIL rnd%0d_no_req: got lat %0d expected -1", it, r_lat); end
      end
      checks++; if ({r_dt, r_be_err} !== {m.dtack, m.berr}) begin failures++; $display("FAIL rnd%0d_term: dtack=%b berr=%b expected %b %b", it, r_dt, r_be_err, m.dtack, m.berr); end
      if (m.dtack || m.berr) begin
        checks++; if (r_resp !== m.resp_lat || r_hold !== {m.dtack, m.berr}) begin failures++; $display("FAIL rnd%0d_resp: lat=%0d hold=%b expected %0d %b", it, r_resp, r_hold, m.resp_lat, {m.dtack, m.berr}); end
      end
      if (rd) begin
        checks++; if (r_rd !== (m.dtack ? rdv : 16'hFFFF)) begin failures++; $display("FAIL rnd%0d_rdata: got %h expected %h", it, r_rd, m.dtack ? rdv : 16'hFFFF); end
      end
      checks++; if (!r_rel || r_ovl) begin failures++; $display("FAIL rnd%0d_release: rel=%b overlap=%b expected 1 0", it, r_rel, r_ovl); end
    end
  endtask

  initial begin
    addr = '0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; read = 1'b1; fc = 3'b101;
    tb_drv = 1'b0; tb_wd = '0; be_ack = 1'b0; be_rdata = '0;
    #2;
    test_reset();
    test_word_read();
    test_byte_write();
    test_miss();
    test_timeout();
    test_ack_at_timeout();
    test_withdraw();
    test_reset_in_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
